fifo_wr_traffic_gen: RTL and testbench

Producer-side traffic generator for the FIFO-with-parity-checker testbench, driving the FIFO write port opposite the consumer-side read-grant generator. It offers an incrementing data stream with even parity at a selectable bandwidth (0 %, ~50 % pseudo-random, 100 %) and obeys the FIFO's `full` back-pressure. It counts accepted words so the scoreboard can cross-check the read side, and can optionally inject parity errors to exercise the checker.

---
 rtl/fifo_wr_traffic_gen.sv | 102 ++++++++++
 tb/tb_fifo_wr_traffic_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_traffic_gen.sv
// rtl/fifo_wr_traffic_gen.sv - FIFO write-side traffic generator with selectable bandwidth
// Optional parity error injection: FIFO_WR_GEN_PARITY_ERR_INJ_EN
module fifo_wr_traffic_gen #(
  parameter int          DATA_W     = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          ERR_PERIOD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        bw_ctrl,
  input  logic              full,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_out,
  output logic [15:0]       words_sent,
  output logic [15:0]       errs_injected
);

`ifdef FIFO_WR_GEN_PARITY_ERR_INJ_EN
  localparam bit INJ_EN = 1'b1;
`else
  localparam bit INJ_EN = 1'b0;
`endif

  localparam logic [15:0] ERR_LAST = 16'(ERR_PERIOD - 1);

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [15:0]         lfsr;
  logic                go;
  logic                accept;
  logic [DATA_W-1:0]   data_nxt;
  logic [15:0]         err_idx;
  logic [15:0]         err_idx_nxt;
  logic                inj_nxt;

  // Free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_comb begin
    go = 1'b0;
    case (bw_ctrl)
      2'd1:    go = lfsr[0];
      2'd2:    go = 1'b1;
      default: go = 1'b0;
    endcase
  end

  assign accept = valid_out && !full;

  always_comb begin
    state_nxt   = state;
    data_nxt    = data_out + DATA_W'(1);
    err_idx_nxt = (err_idx == ERR_LAST) ? 16'd0 : err_idx + 16'd1;
    inj_nxt     = INJ_EN && (err_idx_nxt == ERR_LAST);
    case (state)
      IDLE: begin
        if (go) state_nxt = OFFER;
      end
      OFFER: begin
        // A pending word is never withdrawn; go only matters after acceptance
        if (accept) state_nxt = go ? OFFER : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      valid_out     <= 1'b0;
      data_out      <= '0;
      parity_out    <= 1'b0;
      err_idx       <= 16'd0;
      words_sent    <= 16'd0;
      errs_injected <= 16'd0;
    end else begin
      state     <= state_nxt;
      valid_out <= (state_nxt == OFFER);
      if (accept) begin
        data_out   <= data_nxt;
        parity_out <= (^data_nxt) ^ inj_nxt;
        err_idx    <= err_idx_nxt;
        if (words_sent != 16'hFFFF) words_sent <= words_sent + 16'd1;
        if (INJ_EN && (err_idx == ERR_LAST) && (errs_injected != 16'hFFFF))
          errs_injected <= errs_injected + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_traffic_gen.sv
// tb/tb_fifo_wr_traffic_gen.sv - directed self-checking bench for fifo_wr_traffic_gen
module tb_fifo_wr_traffic_gen;

  logic        clk;
  logic        rst_n;
  logic [1:0]  bw_ctrl;
  logic        full;
  logic        valid_out;
  logic [7:0]  data_out;
  logic        parity_out;
  logic [15:0] words_sent;
  logic [15:0] errs_injected;

  int checks = 0;
  int errors = 0;

`ifdef FIFO_WR_GEN_PARITY_ERR_INJ_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  fifo_wr_traffic_gen #(
    .DATA_W    (8),
    .LFSR_SEED (16'hACE1),
    .ERR_PERIOD(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bw_ctrl      (bw_ctrl),
    .full         (full),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .parity_out   (parity_out),
    .words_sent   (words_sent),
    .errs_injected(errs_injected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_par(input int n);
    logic [7:0] d;
    d = n[7:0];
    return (^d) ^ (INJ && (((n + 1) % 16) == 0));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic prev_acc;

    rst_n   = 1'b0;
    bw_ctrl = 2'd2;
    full    = 1'b0;
    #12;
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_parity", parity_out, 0);
    chk("rst_words", words_sent, 0);
    chk("rst_errs", errs_injected, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // BW_100 streaming: one word per cycle from cycle 1
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bw100_valid", valid_out, 1);
      chk("bw100_data", data_out, 32'(i));
      chk("bw100_parity", parity_out, 32'(exp_par(i)));
      chk("bw100_words", words_sent, 32'(i));
    end
    step();
    chk("bw100_words10", words_sent, 10);
    chk("bw100_data10", data_out, 10);
    chk("bw100_errs", errs_injected, 0);

    // Back-pressure stall at word 3
    do_reset();
    for (int i = 0; i < 4; i++) step();
    chk("stall_pre_data", data_out, 3);
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", valid_out, 1);
      chk("stall_data", data_out, 3);
      chk("stall_parity", parity_out, 0);
      chk("stall_words", words_sent, 3);
    end
    full = 1'b0;
    step();
    chk("stall_next_data", data_out, 4);
    chk("stall_next_words", words_sent, 4);
    chk("stall_next_valid", valid_out, 1);

    // Switch to BW_000 with a pending word under full
    full    = 1'b1;
    bw_ctrl = 2'd0;
    step();
    chk("bw0_hold_valid", valid_out, 1);
    chk("bw0_hold_data", data_out, 4);
    full = 1'b0;
    step();
    chk("bw0_acc_valid", valid_out, 0);
    chk("bw0_acc_words", words_sent, 5);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bw0_idle_valid", valid_out, 0);
      chk("bw0_idle_words", words_sent, 5);
    end

    // 300 accepts with 8-bit wrap
    bw_ctrl = 2'd2;
    do_reset();
    for (int k = 0; k <= 300; k++) begin
      step();
      chk("wrap_data", data_out, 32'(k % 256));
      chk("wrap_words", words_sent, 32'(k));
    end
    chk("wrap_errs", errs_injected, INJ ? 18 : 0);

    // BW_050: gap-free sequence at roughly half rate
    bw_ctrl  = 2'd1;
    do_reset();
    n        = 0;
    prev_acc = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (prev_acc) n++;
      chk("bw50_words", words_sent, 32'(n));
      if (valid_out) begin
        chk("bw50_data", data_out, 32'(n % 256));
        chk("bw50_parity", parity_out, 32'(exp_par(n)));
      end
      prev_acc = valid_out && !full;
    end
    chk("bw50_lo", 32'(words_sent >= 16'd400), 1);
    chk("bw50_hi", 32'(words_sent <= 16'd600), 1);

    // Asynchronous reset mid-burst
    bw_ctrl = 2'd2;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    chk("mid_pre_data", data_out, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_parity", parity_out, 0);
    chk("mid_rst_words", words_sent, 0);
    chk("mid_rst_errs", errs_injected, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mid_restart_valid", valid_out, 1);
    chk("mid_restart_data", data_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
